sync_fifo_ctrl: RTL and testbench

//  Single-clock pointer/flag controller for the FIFO dual-port memory (write-enable, write/read address).

---
 rtl/sync_fifo_ctrl_if.sv | 42 ++++
 rtl/sync_fifo_ctrl.sv | 82 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/flag bundle between producer/consumer logic and the FIFO pointer controller.
// Latency: none (wires only).
// Backpressure: FULL/EMPTY gate pushes/pops. ALMOST_* exist only with FIFO_CTRL_WATERMARK_EN.
interface sync_fifo_ctrl_if #(
    parameter int MEM_DEPTH = 8
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic          w_inc;
    logic          r_inc;
    logic          err_clr;
    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr;
    logic [AW-1:0] mem_r_addr;
    logic          full;
    logic          empty;
    logic [AW:0]   fifo_cnt;
    logic          ovf;
    logic          unf;
`ifdef FIFO_CTRL_WATERMARK_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    // Producer/consumer side.
    modport master (
        output w_inc, r_inc, err_clr,
        input  mem_w_en, mem_w_addr, mem_r_addr, full, empty, fifo_cnt, ovf, unf
`ifdef FIFO_CTRL_WATERMARK_EN
        , input almost_full, almost_empty
`endif
    );

    // Controller side.
    modport slave (
        input  w_inc, r_inc, err_clr,
        output mem_w_en, mem_w_addr, mem_r_addr, full, empty, fifo_cnt, ovf, unf
`ifdef FIFO_CTRL_WATERMARK_EN
        , output almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller driving a dual-port memory (FWFT read at mem_r_addr).
// Latency: mem_w_en combinational; flags/count/errors update 1 cycle after the accepting edge.
// Backpressure: push dropped while FULL (sets OVF), pop dropped while EMPTY (sets UNF).
// Optional: `define FIFO_CTRL_WATERMARK_EN adds almost_full/almost_empty outputs.
module sync_fifo_ctrl #(
    parameter int MEM_DEPTH = 8
`ifdef FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 2
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_fifo_ctrl_if.slave ctrl
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        full, empty;
    logic        push_ok, pop_ok;
    logic [AW:0] cnt;

    // Flags come only from registered pointers; the extra wrap bit separates full from empty.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        cnt     = wr_ptr_q - rd_ptr_q;
        push_ok = ctrl.w_inc & ~full;
        pop_ok  = ctrl.r_inc & ~empty;
    end

    // Pointer advance and sticky error next-state; a new error beats a same-cycle clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (ctrl.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ctrl.w_inc && full) begin
            ovf_d = 1'b1;
        end
        if (ctrl.r_inc && empty) begin
            unf_d = 1'b1;
        end
    end

    // State registers; reset discards all contents immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign ctrl.mem_w_en   = push_ok;
    assign ctrl.mem_w_addr = wr_ptr_q[AW-1:0];
    assign ctrl.mem_r_addr = rd_ptr_q[AW-1:0];
    assign ctrl.full       = full;
    assign ctrl.empty      = empty;
    assign ctrl.fifo_cnt   = cnt;
    assign ctrl.ovf        = ovf_q;
    assign ctrl.unf        = unf_q;

`ifdef FIFO_CTRL_WATERMARK_EN
    assign ctrl.almost_full  = (cnt >= (AW+1)'(AF_LEVEL));
    assign ctrl.almost_empty = (cnt <= (AW+1)'(AE_LEVEL));
`endif
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl with an attached 8x8 memory; scoreboard checks read data order.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_fifo_ctrl;
    logic       clk;
    logic       rst_n;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;
    int mcnt   = 0;
    logic [7:0] sb_q[$];

    sync_fifo_ctrl_if #(.MEM_DEPTH(8)) ifc ();

    sync_fifo_ctrl #(.MEM_DEPTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the controller: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ifc.mem_w_en) mem[ifc.mem_w_addr] <= wr_data;
    end
    assign rd_data = mem[ifc.mem_r_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: whenever a pop will be accepted at the next edge, the head word must match.
    always @(negedge clk) begin
        if (rst_n && ifc.r_inc && !ifc.empty) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got 0x%0h, expected no data (scoreboard empty)", rd_data);
            end else begin
                automatic logic [7:0] e = sb_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got 0x%0h, expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    // Apply inputs for the next edge and record what the FIFO must hand back.
    task automatic drive(input logic w, input logic r, input logic clr, input logic [7:0] d);
        ifc.w_inc   = w;
        ifc.r_inc   = r;
        ifc.err_clr = clr;
        wr_data     = d;
        if (w && mcnt != 8) sb_q.push_back(d);
        mcnt = mcnt + ((w && mcnt != 8) ? 1 : 0) - ((r && mcnt != 0) ? 1 : 0);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ifc.w_inc   = 1'b0;
        ifc.r_inc   = 1'b0;
        ifc.err_clr = 1'b0;
    endtask

    task automatic step(input logic w, input logic r, input logic clr, input logic [7:0] d);
        drive(w, r, clr, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        ifc.w_inc   = 1'b0;
        ifc.r_inc   = 1'b0;
        ifc.err_clr = 1'b0;
        wr_data     = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) tick();

        // Reset/idle state.
        chk("reset_empty", ifc.empty, 1);
        chk("reset_full", ifc.full, 0);
        chk("reset_cnt", ifc.fifo_cnt, 0);
        chk("reset_ovf", ifc.ovf, 0);
        chk("reset_unf", ifc.unf, 0);
        chk("reset_wen", ifc.mem_w_en, 0);
        chk("reset_waddr", ifc.mem_w_addr, 0);
        chk("reset_raddr", ifc.mem_r_addr, 0);

        // Fill 0x11..0x88.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'((i + 1) * 8'h11));
            chk("fill_wen", ifc.mem_w_en, 1);
            tick();
            chk("fill_cnt", ifc.fifo_cnt, i + 1);
            chk("fill_full", ifc.full, (i == 7) ? 1 : 0);
`ifdef FIFO_CTRL_WATERMARK_EN
            chk("fill_af", ifc.almost_full, (i + 1 >= 6) ? 1 : 0);
            chk("fill_ae", ifc.almost_empty, (i + 1 <= 2) ? 1 : 0);
`endif
        end

        // Push while full is dropped.
        drive(1'b1, 1'b0, 1'b0, 8'h99);
        chk("ovf_wen", ifc.mem_w_en, 0);
        tick();
        chk("ovf_set", ifc.ovf, 1);
        chk("ovf_cnt", ifc.fifo_cnt, 8);
        chk("ovf_waddr", ifc.mem_w_addr, 0);

        // Drain 8; monitor checks 0x11..0x88.
        repeat (8) step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("drain_empty", ifc.empty, 1);
        chk("drain_cnt", ifc.fifo_cnt, 0);
        chk("ovf_sticky", ifc.ovf, 1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf_clr", ifc.ovf, 0);

        // Pop while empty.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("unf_set", ifc.unf, 1);
        chk("unf_raddr", ifc.mem_r_addr, 0);
        chk("unf_cnt", ifc.fifo_cnt, 0);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("unf_set_wins", ifc.unf, 1);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("unf_clr", ifc.unf, 0);

        // Wrap: 5/5 then 6/6.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
        repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap_waddr5", ifc.mem_w_addr, 5);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'(8'hB0 + i));
            if (i == 2) chk("wrap_waddr0", ifc.mem_w_addr, 0);
        end
        chk("wrap_waddr3", ifc.mem_w_addr, 3);
        repeat (6) step(1'b0, 1'b1, 1'b0, 8'h00);
        chk("wrap_empty", ifc.empty, 1);

        // Full + push + pop.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        chk("fullpp_cnt", ifc.fifo_cnt, 7);
        chk("fullpp_ovf", ifc.ovf, 1);
        repeat (7) step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Empty + push + pop.
        step(1'b1, 1'b1, 1'b0, 8'hDD);
        chk("emptypp_cnt", ifc.fifo_cnt, 1);
        chk("emptypp_unf", ifc.unf, 1);
        chk("emptypp_ovf", ifc.ovf, 0);
        step(1'b0, 1'b1, 1'b1, 8'h00);
        chk("emptypp_drain", ifc.empty, 1);

        // Asynchronous reset mid-stream at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h51 + i));
        chk("pre_rst_cnt", ifc.fifo_cnt, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", ifc.fifo_cnt, 0);
        chk("arst_empty", ifc.empty, 1);
        chk("arst_waddr", ifc.mem_w_addr, 0);
`ifdef FIFO_CTRL_WATERMARK_EN
        chk("arst_ae", ifc.almost_empty, 1);
        chk("arst_af", ifc.almost_full, 0);
`endif
        sb_q.delete();
        mcnt = 0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("post_rst_empty", ifc.empty, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
